// File: rtl/silife_max7219_ctrl.sv
// Sequencer for a cascade of MAX7219 LED matrix drivers: builds the config and
// frame-row word groups, drives LOAD (o_cs_n) and handshakes with a 16-bit SPI master.
module silife_max7219_ctrl #(
  parameter int NUM_CHIPS      = 1,
  parameter int CS_HIGH_CYCLES = 2,
  localparam int CW = (NUM_CHIPS > 1) ? $clog2(NUM_CHIPS) : 1
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          i_enable,
  input  logic          i_refresh,
  input  logic          i_reinit,
  input  logic [3:0]    i_intensity,
  output logic          o_rd_en,
  output logic [CW-1:0] o_rd_chip,
  output logic [2:0]    o_rd_row,
  input  logic [7:0]    i_rd_data,
  output logic [15:0]   o_spi_word,
  output logic          o_spi_start,
  input  logic          i_spi_busy,
  output logic          o_cs_n,
  output logic          o_ready,
  output logic          o_busy,
  output logic          o_frame_done,
  output logic [2:0]    o_dbg_state
);

  // SPI handshake: o_spi_start is a one-cycle request with o_spi_word already
  // valid; the master raises i_spi_busy while shifting and drops it when done.
  // o_spi_word is held from the start pulse until i_spi_busy falls.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_SETUP = 3'd1,
    FETCH    = 3'd2,
    ISSUE    = 3'd3,
    WAIT_HI  = 3'd4,
    WAIT_LO  = 3'd5,
    CS_HOLD  = 3'd6,
    CS_GAP   = 3'd7
  } state_t;

  localparam logic [CW-1:0] LAST_CHIP = CW'(NUM_CHIPS - 1);
  localparam int            GW        = ($clog2(CS_HIGH_CYCLES) > 0) ? $clog2(CS_HIGH_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST  = GW'(CS_HIGH_CYCLES - 1);

  state_t        state;
  state_t        state_d;
  logic [CW-1:0] chip_idx;
  logic [2:0]    grp_idx;
  logic [GW-1:0] gap_cnt;
  logic          is_cfg;
  logic          fetch_wait;
  logic          cfg_pend;
  logic          ref_pend;
  logic          boot;
  logic          last_grp;
  logic          job_start;
  logic          job_abort;

  function automatic logic [15:0] cfg_word(input logic [2:0] g, input logic [3:0] inten);
    logic [15:0] w;
    case (g)
      3'd0:    w = 16'h0F00;
      3'd1:    w = 16'h0B07;
      3'd2:    w = 16'h0900;
      3'd3:    w = {8'h0A, 4'h0, inten};
      default: w = 16'h0C01;
    endcase
    return w;
  endfunction

  assign last_grp  = is_cfg ? (grp_idx == 3'd4) : (grp_idx == 3'd7);
  assign job_start = (state == IDLE) && (state_d == CS_SETUP);
  assign job_abort = (state == CS_GAP) && (state_d == IDLE) && !i_enable;

  assign o_rd_en     = (state == FETCH) && !fetch_wait;
  assign o_rd_chip   = chip_idx;
  assign o_rd_row    = grp_idx;
  assign o_spi_start = (state == ISSUE);
  assign o_busy      = (state != IDLE);
  assign o_dbg_state = state;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE:     if (i_enable && (cfg_pend || ref_pend)) state_d = CS_SETUP;
      CS_SETUP: state_d = is_cfg ? ISSUE : FETCH;
      FETCH:    if (fetch_wait) state_d = ISSUE;
      ISSUE:    state_d = WAIT_HI;
      WAIT_HI:  if (i_spi_busy) state_d = WAIT_LO;
      WAIT_LO: begin
        if (!i_spi_busy) begin
          if (chip_idx != '0) state_d = is_cfg ? ISSUE : FETCH;
          else                state_d = CS_HOLD;
        end
      end
      CS_HOLD:  state_d = CS_GAP;
      CS_GAP: begin
        if (gap_cnt == GAP_LAST) state_d = (last_grp || !i_enable) ? IDLE : CS_SETUP;
      end
      default:  state_d = IDLE;
    endcase
  end

  // Request flags: a new request in the same cycle as the clear wins, so a
  // reinit during a running config sequence re-arms it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      boot     <= 1'b1;
      cfg_pend <= 1'b0;
      ref_pend <= 1'b0;
    end else begin
      if (job_start && cfg_pend) cfg_pend <= 1'b0;
      if (i_reinit || (boot && i_enable)) cfg_pend <= 1'b1;
      if (boot && i_enable) boot <= 1'b0;

      if ((job_start && !cfg_pend) || job_abort) ref_pend <= 1'b0;
      if (i_refresh) ref_pend <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      o_cs_n       <= 1'b1;
      o_spi_word   <= 16'h0000;
      o_ready      <= 1'b0;
      o_frame_done <= 1'b0;
      chip_idx     <= '0;
      grp_idx      <= 3'd0;
      gap_cnt      <= '0;
      is_cfg       <= 1'b0;
      fetch_wait   <= 1'b0;
    end else begin
      o_frame_done <= 1'b0;
      case (state)
        IDLE: begin
          if (job_start) begin
            is_cfg   <= cfg_pend;
            grp_idx  <= 3'd0;
            chip_idx <= LAST_CHIP;
            o_cs_n   <= 1'b0;
          end
        end
        CS_SETUP: begin
          if (is_cfg) o_spi_word <= cfg_word(grp_idx, i_intensity);
        end
        FETCH: begin
          // First cycle strobes the read; the row data arrives one cycle later.
          fetch_wait <= !fetch_wait;
          if (fetch_wait) o_spi_word <= {4'h0, {1'b0, grp_idx} + 4'd1, i_rd_data};
        end
        WAIT_LO: begin
          if (!i_spi_busy && (chip_idx != '0)) chip_idx <= chip_idx - 1'b1;
        end
        CS_HOLD: begin
          o_cs_n  <= 1'b1;
          gap_cnt <= '0;
          if (last_grp && is_cfg)  o_ready      <= 1'b1;
          if (last_grp && !is_cfg) o_frame_done <= 1'b1;
        end
        CS_GAP: begin
          gap_cnt <= gap_cnt + 1'b1;
          if (state_d == CS_SETUP) begin
            grp_idx  <= grp_idx + 3'd1;
            chip_idx <= LAST_CHIP;
            o_cs_n   <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
